reg_file_sb: RTL and testbench

- Parametrised, scoreboarded successor to the accumulator register file.
- Two write ports:
  - Port 0: ALU/writeback. The destination is either rs or the accumulator, selected by the decoder.
  - Port 1: load return from data memory.
- Per-register busy bits track outstanding loads.
- Optional write-to-read bypass.
- Sits between decode and ALU. The core stalls on busy_a/busy_b.

---
 rtl/reg_file_sb_pkg.sv | 25 ++
 rtl/reg_sb_scoreboard.sv | 72 +++++++
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared register-file definitions: pointer type, accumulator index, opcodes.
package reg_file_sb_pkg;

  localparam int unsigned kD   = 4;
  localparam int unsigned kW   = 8;
  localparam int unsigned kACC = 0;

  typedef logic [kD-1:0] reg_ptr_t;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD_A  = 4'h1,
    OP_ADD_RS = 4'h2,
    OP_MOV_A  = 4'h3,
    OP_MOV_RS = 4'h4,
    OP_LD     = 4'h5,
    OP_ST     = 4'h6
  } opcode_t;

  // Decoder helper: ALU results of *_RS opcodes land in rs, the rest in ACC.
  function automatic logic op_writes_rs(opcode_t op);
    return (op == OP_ADD_RS) || (op == OP_MOV_RS);
  endfunction

endpackage

// File: rtl/reg_sb_scoreboard.sv
// Purpose: per-register busy bits for outstanding loads plus sticky hazard flag.
// Latency: busy/err update at the rising edge after issue/return/write.
// Backpressure: none; consumers stall on the busy vector.
module reg_sb_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned D = kD
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               issue,
  input  logic [D-1:0]       issue_addr,
  input  logic               ret_vld,
  input  logic [D-1:0]       ret_addr,
  input  logic               alu_vld,
  input  logic [D-1:0]       alu_addr,
  output logic [(1<<D)-1:0]  busy,
  output logic               err
);

  localparam int N = 1 << D;

  // cancel marks a load whose destination was overwritten by the ALU; its
  // eventual return is the WAW hazard. Registers freed by reset are not marked.
  logic [N-1:0] busy_nxt;
  logic [N-1:0] cancel;
  logic [N-1:0] cancel_nxt;
  logic         err_nxt;

  always_comb begin
    busy_nxt   = busy;
    cancel_nxt = cancel;
    err_nxt    = err;
    for (int i = 0; i < N; i++) begin
      if (issue && issue_addr == D'(i)) begin
        busy_nxt[i] = 1'b1;
      end else if ((ret_vld && ret_addr == D'(i)) || (alu_vld && alu_addr == D'(i))) begin
        busy_nxt[i] = 1'b0;
      end
      if (alu_vld && alu_addr == D'(i) && busy[i] && !(ret_vld && ret_addr == D'(i))) begin
        cancel_nxt[i] = 1'b1;
      end else if (ret_vld && ret_addr == D'(i)) begin
        cancel_nxt[i] = 1'b0;
      end
    end
    if (issue && busy[issue_addr] && !(ret_vld && ret_addr == issue_addr)) begin
      err_nxt = 1'b1;
    end
    if (ret_vld && !busy[ret_addr] && cancel[ret_addr]) begin
      err_nxt = 1'b1;
    end
    if (clr) begin
      busy_nxt   = '0;
      cancel_nxt = '0;
      err_nxt    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= '0;
      cancel <= '0;
      err    <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      cancel <= cancel_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Purpose: scoreboarded register file, ALU + load-return write ports, optional bypass.
// Latency: writes visible next cycle (same cycle when FWD=1); reads combinational.
// Backpressure: none; core stalls on busy_a/busy_b.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned W   = kW,
  parameter int unsigned D   = kD,
  parameter int unsigned ACC = kACC,
  parameter int unsigned FWD = 1
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [D-1:0] raddr_a,
  input  logic [D-1:0] raddr_b,
  output logic [W-1:0] data_out_a,
  output logic [W-1:0] data_out_b,
  output logic         busy_a,
  output logic         busy_b,
  input  logic         wr_en,
  input  logic         wr_to_rs,
  input  logic [D-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         ld_issue,
  input  logic [D-1:0] ld_addr,
  input  logic         ld_ret_valid,
  input  logic [D-1:0] ld_ret_addr,
  input  logic [W-1:0] ld_ret_data,
  output logic         err
);

  localparam int N = 1 << D;
  localparam logic [D-1:0] ACC_PTR = ACC[D-1:0];

  logic [W-1:0] regs [N];
  logic [N-1:0] busy;
  logic [D-1:0] wa;

  assign wa = wr_to_rs ? wr_addr : ACC_PTR;

  reg_sb_scoreboard #(.D(D)) u_sb (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .clr        (clr),
    .issue      (ld_issue),
    .issue_addr (ld_addr),
    .ret_vld    (ld_ret_valid),
    .ret_addr   (ld_ret_addr),
    .alu_vld    (wr_en),
    .alu_addr   (wa),
    .busy       (busy),
    .err        (err)
  );

  // ALU write is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else begin
      if (ld_ret_valid) regs[ld_ret_addr] <= ld_ret_data;
      if (wr_en)        regs[wa]          <= wr_data;
    end
  end

  // Bypass is held off during reset so outputs read as zero while reset_n is low.
  always_comb begin
    data_out_a = regs[raddr_a];
    data_out_b = regs[raddr_b];
    busy_a     = busy[raddr_a];
    busy_b     = busy[raddr_b];
    if (FWD != 0 && reset_n) begin
      if (wr_en && wa == raddr_a) begin
        data_out_a = wr_data;
        busy_a     = 1'b0;
      end else if (ld_ret_valid && ld_ret_addr == raddr_a) begin
        data_out_a = ld_ret_data;
        busy_a     = 1'b0;
      end
      if (wr_en && wa == raddr_b) begin
        data_out_b = wr_data;
        busy_b     = 1'b0;
      end else if (ld_ret_valid && ld_ret_addr == raddr_b) begin
        data_out_b = ld_ret_data;
        busy_b     = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb: bypass build (u_fwd) and committed-only build (u_nofwd).
module tb_reg_file_sb;

  logic       CLK;
  logic       reset_n;
  logic       clr;
  logic [3:0] raddr_a, raddr_b;
  logic       wr_en, wr_to_rs;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       ld_issue;
  logic [3:0] ld_addr;
  logic       ld_ret_valid;
  logic [3:0] ld_ret_addr;
  logic [7:0] ld_ret_data;

  logic [7:0] f_a, f_b, n_a, n_b;
  logic       f_ba, f_bb, f_err, n_ba, n_bb, n_err;

  int n_vec = 0;
  int n_bad = 0;

  reg_file_sb #(.W(8), .D(4), .ACC(0), .FWD(1)) u_fwd (
    .CLK(CLK), .reset_n(reset_n), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .data_out_a(f_a), .data_out_b(f_b), .busy_a(f_ba), .busy_b(f_bb),
    .wr_en(wr_en), .wr_to_rs(wr_to_rs), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr),
    .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
    .err(f_err)
  );

  reg_file_sb #(.W(8), .D(4), .ACC(0), .FWD(0)) u_nofwd (
    .CLK(CLK), .reset_n(reset_n), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .data_out_a(n_a), .data_out_b(n_b), .busy_a(n_ba), .busy_b(n_bb),
    .wr_en(wr_en), .wr_to_rs(wr_to_rs), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr),
    .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
    .err(n_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       clr;
    logic       wr_en;
    logic       wr_to_rs;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       ld_issue;
    logic [3:0] ld_addr;
    logic       ret;
    logic [3:0] ret_addr;
    logic [7:0] ret_data;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eba;
    logic       ebb;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic we, logic wrs, logic [3:0] wad, logic [7:0] wd,
                              logic li, logic [3:0] la, logic rv, logic [3:0] rad, logic [7:0] rd,
                              logic [3:0] ra, logic [3:0] rb, logic [7:0] ea, logic [7:0] eb,
                              logic eba, logic ebb, logic eerr);
    vec_t v;
    v.clr = c; v.wr_en = we; v.wr_to_rs = wrs; v.wr_addr = wad; v.wr_data = wd;
    v.ld_issue = li; v.ld_addr = la; v.ret = rv; v.ret_addr = rad; v.ret_data = rd;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; wr_to_rs = 1'b0; wr_addr = '0; wr_data = '0;
    ld_issue = 1'b0; ld_addr = '0; ld_ret_valid = 1'b0; ld_ret_addr = '0; ld_ret_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //    clr we wrs wad  wd     li la   rv rad  rd     ra   rb   ea     eb     ba bb err
    vecs.push_back(mk(0, 1, 0, 4'h0, 8'h3C, 0, 4'h0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h3C, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h5, 4'h0, 8'h00, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1, 4'h5, 0, 4'h0, 8'h00, 4'h5, 4'h0, 8'h00, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h5, 4'h0, 8'h00, 8'h3C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h5, 4'h0, 8'h00, 8'h3C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 1, 4'h5, 8'hA5, 4'h5, 4'h0, 8'hA5, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h5, 4'h0, 8'hA5, 8'h3C, 0, 0, 0));
    // same-address ALU write and load return: ALU data wins
    vecs.push_back(mk(0, 1, 1, 4'h7, 8'h11, 0, 4'h0, 1, 4'h7, 8'h22, 4'h7, 4'h0, 8'h11, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h7, 4'h0, 8'h11, 8'h3C, 0, 0, 0));
    // double issue to reg 3, err sticky until clr
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1, 4'h3, 0, 4'h0, 8'h00, 4'h3, 4'h0, 8'h00, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1, 4'h3, 0, 4'h0, 8'h00, 4'h3, 4'h0, 8'h00, 8'h3C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h3, 4'h0, 8'h00, 8'h3C, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h3, 4'h0, 8'h00, 8'h3C, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h3, 4'h0, 8'h00, 8'h3C, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h3, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    // ALU overwrites a pending load; the late return is a WAW hazard
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1, 4'h4, 0, 4'h0, 8'h00, 4'h4, 4'h0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'h4, 8'h66, 0, 4'h0, 0, 4'h0, 8'h00, 4'h4, 4'h0, 8'h66, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h4, 4'h0, 8'h66, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 1, 4'h4, 8'h77, 4'h4, 4'h0, 8'h77, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h4, 4'h0, 8'h77, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h4, 4'h0, 8'h77, 8'h00, 0, 0, 1));
    // issue + return to same reg: data written, busy stays set, no err
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1, 4'h6, 1, 4'h6, 8'h5A, 4'h6, 4'h0, 8'h5A, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h6, 4'h0, 8'h5A, 8'h00, 1, 0, 0));
    // issue + ALU write to same reg: data written, busy ends set
    vecs.push_back(mk(0, 1, 1, 4'h8, 8'h99, 1, 4'h8, 0, 4'h0, 8'h00, 4'h8, 4'h6, 8'h99, 8'h5A, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h8, 4'h6, 8'h99, 8'h5A, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 1, 4'h8, 8'h12, 4'h8, 4'h6, 8'h12, 8'h5A, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h8, 4'h6, 8'h12, 8'h5A, 0, 1, 0));
    // both ports, different addresses
    vecs.push_back(mk(0, 1, 1, 4'hA, 8'hC3, 0, 4'h0, 1, 4'hB, 8'h3C, 4'hA, 4'hB, 8'hC3, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'hA, 4'hB, 8'hC3, 8'h3C, 0, 0, 0));
    // top register index
    vecs.push_back(mk(0, 1, 1, 4'hF, 8'hFF, 0, 4'h0, 0, 4'h0, 8'h00, 4'hF, 4'h6, 8'hFF, 8'h5A, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'hF, 4'h0, 8'hFF, 8'h00, 0, 0, 0));
    // wr_to_rs=0 ignores wr_addr and targets ACC
    vecs.push_back(mk(0, 1, 0, 4'h9, 8'hE1, 0, 4'h0, 0, 4'h0, 8'h00, 4'h9, 4'h0, 8'h00, 8'hE1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 4'h9, 4'h0, 8'h00, 8'hE1, 0, 0, 0));

    // reset state, with a write strobe present to confirm outputs stay zero
    idle();
    reset_n = 1'b0;
    raddr_a = 4'h0; raddr_b = 4'h0;
    wr_en = 1'b1; wr_data = 8'hAA;
    #12;
    chk8("reset data_a", f_a, 8'h00);
    chk8("reset data_b", f_b, 8'h00);
    chk1("reset busy_a", f_ba, 1'b0);
    chk1("reset err", f_err, 1'b0);
    chk8("reset nofwd data_b", n_b, 8'h00);
    idle();
    reset_n = 1'b1;
    next_cycle();

    foreach (vecs[k]) begin
      clr = vecs[k].clr; wr_en = vecs[k].wr_en; wr_to_rs = vecs[k].wr_to_rs;
      wr_addr = vecs[k].wr_addr; wr_data = vecs[k].wr_data;
      ld_issue = vecs[k].ld_issue; ld_addr = vecs[k].ld_addr;
      ld_ret_valid = vecs[k].ret; ld_ret_addr = vecs[k].ret_addr; ld_ret_data = vecs[k].ret_data;
      raddr_a = vecs[k].ra; raddr_b = vecs[k].rb;
      @(negedge CLK);
      chk8($sformatf("v%0d data_a", k), f_a, vecs[k].ea);
      chk8($sformatf("v%0d data_b", k), f_b, vecs[k].eb);
      chk1($sformatf("v%0d busy_a", k), f_ba, vecs[k].eba);
      chk1($sformatf("v%0d busy_b", k), f_bb, vecs[k].ebb);
      chk1($sformatf("v%0d err", k), f_err, vecs[k].eerr);
      next_cycle();
    end

    // asynchronous reset with a load in flight
    idle();
    ld_issue = 1'b1; ld_addr = 4'h9;
    wr_en = 1'b1; wr_to_rs = 1'b1; wr_addr = 4'h2; wr_data = 8'hFF;
    next_cycle();
    idle();
    raddr_a = 4'h9; raddr_b = 4'h2;
    #1;
    chk1("pre-reset busy_a", f_ba, 1'b1);
    chk8("pre-reset data_b", f_b, 8'hFF);
    reset_n = 1'b0;
    #1;
    chk8("async reset data_b", f_b, 8'h00);
    chk1("async reset busy_a", f_ba, 1'b0);
    chk8("async reset nofwd data_b", n_b, 8'h00);
    chk1("async reset nofwd busy_a", n_ba, 1'b0);
    @(negedge CLK);
    reset_n = 1'b1;
    next_cycle();
    ld_ret_valid = 1'b1; ld_ret_addr = 4'h9; ld_ret_data = 8'h44;
    next_cycle();
    idle();
    #1;
    chk8("post-reset ret data_a", f_a, 8'h44);
    chk1("post-reset ret busy_a", f_ba, 1'b0);
    chk1("post-reset ret err", f_err, 1'b0);
    chk1("post-reset ret nofwd err", n_err, 1'b0);

    // load round trip on the committed-only build
    raddr_a = 4'h5; raddr_b = 4'h0;
    wr_en = 1'b1; wr_to_rs = 1'b1; wr_addr = 4'h5; wr_data = 8'h5F;
    #1;
    chk8("nofwd write-cycle data_a", n_a, 8'h00);
    next_cycle();
    idle();
    ld_issue = 1'b1; ld_addr = 4'h5;
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    ld_ret_valid = 1'b1; ld_ret_addr = 4'h5; ld_ret_data = 8'hA5;
    #1;
    chk8("nofwd ret-cycle data_a", n_a, 8'h5F);
    chk1("nofwd ret-cycle busy_a", n_ba, 1'b1);
    chk8("fwd ret-cycle data_a", f_a, 8'hA5);
    chk1("fwd ret-cycle busy_a", f_ba, 1'b0);
    next_cycle();
    idle();
    #1;
    chk8("nofwd after-ret data_a", n_a, 8'hA5);
    chk1("nofwd after-ret busy_a", n_ba, 1'b0);
    chk1("nofwd after-ret err", n_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
